// File: rtl/time_pkg.sv
// Field/state codes shared between the time-set controller and the time keeper,
// plus the per-field wrap limits.
package time_pkg;

    typedef enum logic [1:0] {
        FIELD_RUN  = 2'b00,
        FIELD_SEC  = 2'b01,
        FIELD_MIN  = 2'b10,
        FIELD_HOUR = 2'b11
    } field_t;

    localparam int HOUR_LIM    = 24;
    localparam int MIN_SEC_LIM = 60;

    // Largest legal value of a field (LIM-1).
    function automatic logic [5:0] field_max(input field_t f);
        return (f == FIELD_HOUR) ? 6'(HOUR_LIM - 1) : 6'(MIN_SEC_LIM - 1);
    endfunction

    function automatic logic [5:0] clamp_value(input logic [5:0] v, input field_t f);
        return (v > field_max(f)) ? field_max(f) : v;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, tick-based debounce, press pulse and
// optional hold-to-repeat. step_o is a one-clk pulse for a press or a repeat.
module btn_debounce #(
    parameter int DEBOUNCE_TICKS = 2,
    parameter int HOLD_TICKS     = 50,
    parameter int REPEAT_TICKS   = 10,
    parameter bit REPEAT_EN      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic btn_i,
    input  logic repeat_block_i,
    output logic level_o,
    output logic step_o
);

    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    logic          sync1_q, sync2_q;
    logic          level_q;
    logic          step_q;
    logic [DW-1:0] deb_q;
    logic [HW-1:0] hold_q;
    logic [RW-1:0] rep_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            step_q  <= 1'b0;
            deb_q   <= '0;
            hold_q  <= '0;
            rep_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            step_q  <= 1'b0;

            // Any clock where the input agrees with the level restarts the count.
            if (sync2_q == level_q) begin
                deb_q <= '0;
            end else if (tick_i) begin
                if (deb_q == DW'(DEBOUNCE_TICKS - 1)) begin
                    level_q <= sync2_q;
                    deb_q   <= '0;
                    step_q  <= sync2_q;
                end else begin
                    deb_q <= deb_q + 1'b1;
                end
            end

            if (!level_q || !REPEAT_EN) begin
                hold_q <= '0;
                rep_q  <= '0;
            end else if (tick_i) begin
                if (hold_q != HW'(HOLD_TICKS)) begin
                    hold_q <= hold_q + 1'b1;
                    rep_q  <= '0;
                    if (hold_q == HW'(HOLD_TICKS - 1) && !repeat_block_i) step_q <= 1'b1;
                end else if (rep_q == RW'(REPEAT_TICKS - 1)) begin
                    rep_q <= '0;
                    if (!repeat_block_i) step_q <= 1'b1;
                end else begin
                    rep_q <= rep_q + 1'b1;
                end
            end
        end
    end

    assign level_o = level_q;
    assign step_o  = step_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven edit controller for the time keeper: walks hour/minute/second
// edit states and steps the selected field with wrap-around, repeat and timeout.
module time_set_ctrl
    import time_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 2,
    parameter int HOLD_TICKS     = 50,
    parameter int REPEAT_TICKS   = 10,
    parameter int TIMEOUT_TICKS  = 1000,
    parameter int BLINK_TICKS    = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_10ms,
    input  logic       power_on,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic [5:0] cur_second,
    output logic [1:0] set_all_times,
    output logic [5:0] btn_time_set,
    output logic       editing,
    output logic       blink
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    logic mode_step, up_step, dn_step;
    logic up_level, dn_level, mode_level_unused;
    logic up_ev, dn_ev;

    field_t        state_q;
    logic [5:0]    value_q;
    logic [TW-1:0] tmo_q;
    logic [BW-1:0] blink_cnt_q;
    logic          editing_q, blink_q;

    field_t        next_field;
    logic [5:0]    next_load;

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .HOLD_TICKS(HOLD_TICKS),
                   .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(1'b0)) u_mode (
        .clk(clk), .reset(reset), .tick_i(tick_10ms), .btn_i(btn_mode),
        .repeat_block_i(1'b1), .level_o(mode_level_unused), .step_o(mode_step));

    // Holding both up and down suppresses repeats on either button.
    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .HOLD_TICKS(HOLD_TICKS),
                   .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(1'b1)) u_up (
        .clk(clk), .reset(reset), .tick_i(tick_10ms), .btn_i(btn_up),
        .repeat_block_i(dn_level), .level_o(up_level), .step_o(up_step));

    btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS), .HOLD_TICKS(HOLD_TICKS),
                   .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(1'b1)) u_down (
        .clk(clk), .reset(reset), .tick_i(tick_10ms), .btn_i(btn_down),
        .repeat_block_i(up_level), .level_o(dn_level), .step_o(dn_step));

    assign up_ev = up_step & ~dn_step;
    assign dn_ev = dn_step & ~up_step;

    always_comb begin
        next_field = FIELD_RUN;
        next_load  = value_q;
        case (state_q)
            FIELD_RUN: begin
                next_field = FIELD_HOUR;
                next_load  = clamp_value(cur_hour, FIELD_HOUR);
            end
            FIELD_HOUR: begin
                next_field = FIELD_MIN;
                next_load  = clamp_value(cur_minute, FIELD_MIN);
            end
            FIELD_MIN: begin
                next_field = FIELD_SEC;
                next_load  = clamp_value(cur_second, FIELD_SEC);
            end
            default: begin
                next_field = FIELD_RUN;
                next_load  = value_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FIELD_RUN;
            value_q     <= '0;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
            editing_q   <= 1'b0;
            blink_q     <= 1'b0;
        end else if (state_q != FIELD_RUN &&
                     (!power_on || (tick_10ms && tmo_q == TW'(TIMEOUT_TICKS - 1)))) begin
            state_q     <= FIELD_RUN;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
            editing_q   <= 1'b0;
            blink_q     <= 1'b0;
        end else if (mode_step && (state_q != FIELD_RUN || power_on)) begin
            state_q     <= next_field;
            value_q     <= next_load;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
            editing_q   <= (next_field != FIELD_RUN);
            blink_q     <= (next_field != FIELD_RUN);
        end else if (state_q != FIELD_RUN && (up_ev || dn_ev)) begin
            if (up_ev) value_q <= (value_q == field_max(state_q)) ? 6'd0 : value_q + 6'd1;
            else       value_q <= (value_q == 6'd0) ? field_max(state_q) : value_q - 6'd1;
            tmo_q       <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else if (state_q != FIELD_RUN && tick_10ms) begin
            if (tmo_q != TW'(TIMEOUT_TICKS)) tmo_q <= tmo_q + 1'b1;
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_q <= '0;
                blink_q     <= ~blink_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign set_all_times = state_q;
    assign btn_time_set  = value_q;
    assign editing       = editing_q;
    assign blink         = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: ticks are driven explicitly so every
// expected value below is counted by hand from the button timing.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset, tick_10ms, power_on;
    logic       btn_mode, btn_up, btn_down;
    logic [5:0] cur_hour, cur_minute, cur_second;
    logic [1:0] set_all_times;
    logic [5:0] btn_time_set;
    logic       editing, blink;

    int n_cmp = 0;
    int n_err = 0;

    time_set_ctrl dut (
        .clk(clk), .reset(reset), .tick_10ms(tick_10ms), .power_on(power_on),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
        .set_all_times(set_all_times), .btn_time_set(btn_time_set),
        .editing(editing), .blink(blink));

    always #5 clk = ~clk;

    // One tick: two clocks for the synchronizer, the strobe, then one clock for
    // the controller to act on any resulting event. Starts and ends on negedge.
    task automatic do_tick();
        repeat (2) @(negedge clk);
        tick_10ms = 1'b1;
        @(negedge clk);
        tick_10ms = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic drive_btn(input int which, input logic v);
        case (which)
            0: btn_mode = v;
            1: btn_up   = v;
            default: btn_down = v;
        endcase
    endtask

    task automatic press(input int which);
        drive_btn(which, 1'b1);
        do_ticks(2);
        drive_btn(which, 1'b0);
        do_ticks(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing, blink} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_held: got %b/%0d/%b/%b want 00/0/0/0", set_all_times, btn_time_set, editing, blink);
        end
        reset = 1'b0;
        do_ticks(2);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing, blink} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_released: got %b/%0d/%b/%b want 00/0/0/0", set_all_times, btn_time_set, editing, blink);
        end
    endtask

    task automatic test_hour_steps();
        logic [5:0] e;
        power_on = 1'b1; cur_hour = 6'd7; cur_minute = 6'd0; cur_second = 6'd10;
        press(0);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing, blink} !== {2'b11, 6'd7, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL hour_entry: got %b/%0d/%b/%b want 11/7/1/1", set_all_times, btn_time_set, editing, blink);
        end
        for (int i = 0; i < 3; i++) begin
            e = 6'(8 + i);
            press(1);
            n_cmp++;
            if ({set_all_times, btn_time_set, editing} !== {2'b11, e, 1'b1}) begin
                n_err++;
                $display("FAIL hour_up_%0d: got %b/%0d/%b want 11/%0d/1", i, set_all_times, btn_time_set, editing, e);
            end
        end
    endtask

    task automatic test_min_wrap();
        press(0);
        n_cmp++;
        if ({set_all_times, btn_time_set} !== {2'b10, 6'd0}) begin
            n_err++;
            $display("FAIL min_entry: got %b/%0d want 10/0", set_all_times, btn_time_set);
        end
        press(2);
        n_cmp++;
        if ({set_all_times, btn_time_set} !== {2'b10, 6'd59}) begin
            n_err++;
            $display("FAIL min_down_wrap: got %b/%0d want 10/59", set_all_times, btn_time_set);
        end
    endtask

    task automatic test_auto_repeat();
        press(0);
        n_cmp++;
        if ({set_all_times, btn_time_set} !== {2'b01, 6'd10}) begin
            n_err++;
            $display("FAIL sec_entry: got %b/%0d want 01/10", set_all_times, btn_time_set);
        end
        btn_up = 1'b1;
        do_ticks(2);
        do_ticks(49);
        n_cmp++;
        if (btn_time_set !== 6'd11) begin
            n_err++;
            $display("FAIL repeat_before_hold: got %0d want 11", btn_time_set);
        end
        do_ticks(1);
        n_cmp++;
        if (btn_time_set !== 6'd12) begin
            n_err++;
            $display("FAIL repeat_at_50: got %0d want 12", btn_time_set);
        end
        do_ticks(29);
        n_cmp++;
        if (btn_time_set !== 6'd14) begin
            n_err++;
            $display("FAIL repeat_at_79: got %0d want 14", btn_time_set);
        end
        do_ticks(1);
        n_cmp++;
        if (btn_time_set !== 6'd15) begin
            n_err++;
            $display("FAIL repeat_at_80: got %0d want 15", btn_time_set);
        end
        btn_up = 1'b0;
        do_ticks(4);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing, blink} !== {2'b01, 6'd15, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL repeat_release: got %b/%0d/%b/%b want 01/15/1/1", set_all_times, btn_time_set, editing, blink);
        end
    endtask

    task automatic test_mode_beats_step();
        btn_mode = 1'b1; btn_up = 1'b1;
        do_ticks(2);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing, blink} !== {2'b00, 6'd15, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL mode_and_up: got %b/%0d/%b/%b want 00/15/0/0", set_all_times, btn_time_set, editing, blink);
        end
        btn_mode = 1'b0; btn_up = 1'b0;
        do_ticks(2);
        press(1);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing} !== {2'b00, 6'd15, 1'b0}) begin
            n_err++;
            $display("FAIL idle_up_ignored: got %b/%0d/%b want 00/15/0", set_all_times, btn_time_set, editing);
        end
    endtask

    task automatic test_glitch_and_wrap();
        cur_hour = 6'd23;
        press(0);
        n_cmp++;
        if ({set_all_times, btn_time_set} !== {2'b11, 6'd23}) begin
            n_err++;
            $display("FAIL hour23_entry: got %b/%0d want 11/23", set_all_times, btn_time_set);
        end
        press(1);
        n_cmp++;
        if (btn_time_set !== 6'd0) begin
            n_err++;
            $display("FAIL hour_up_wrap: got %0d want 0", btn_time_set);
        end
        btn_up = 1'b1;
        do_ticks(1);
        btn_up = 1'b0;
        do_ticks(3);
        n_cmp++;
        if (btn_time_set !== 6'd0) begin
            n_err++;
            $display("FAIL glitch_one_tick: got %0d want 0", btn_time_set);
        end
        btn_up = 1'b1;
        do_ticks(3);
        btn_up = 1'b0;
        do_ticks(2);
        n_cmp++;
        if (btn_time_set !== 6'd1) begin
            n_err++;
            $display("FAIL held_three_ticks: got %0d want 1", btn_time_set);
        end
    endtask

    task automatic test_up_down_together();
        btn_up = 1'b1; btn_down = 1'b1;
        do_ticks(2);
        n_cmp++;
        if (btn_time_set !== 6'd1) begin
            n_err++;
            $display("FAIL up_down_same_cycle: got %0d want 1", btn_time_set);
        end
        btn_up = 1'b0; btn_down = 1'b0;
        do_ticks(2);
        n_cmp++;
        if ({set_all_times, btn_time_set} !== {2'b11, 6'd1}) begin
            n_err++;
            $display("FAIL up_down_release: got %b/%0d want 11/1", set_all_times, btn_time_set);
        end
    endtask

    task automatic test_power_drop();
        @(negedge clk);
        power_on = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing, blink} !== {2'b00, 6'd1, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL power_drop: got %b/%0d/%b/%b want 00/1/0/0", set_all_times, btn_time_set, editing, blink);
        end
        press(0);
        n_cmp++;
        if ({set_all_times, editing} !== {2'b00, 1'b0}) begin
            n_err++;
            $display("FAIL mode_while_off: got %b/%b want 00/0", set_all_times, editing);
        end
        power_on = 1'b1;
    endtask

    task automatic test_timeout();
        cur_minute = 6'd30;
        press(0);
        press(0);
        n_cmp++;
        if ({set_all_times, btn_time_set} !== {2'b10, 6'd30}) begin
            n_err++;
            $display("FAIL timeout_entry: got %b/%0d want 10/30", set_all_times, btn_time_set);
        end
        // Two release ticks already elapsed since entry; 997 more makes 999.
        do_ticks(997);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing, blink} !== {2'b10, 6'd30, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_999: got %b/%0d/%b/%b want 10/30/1/0", set_all_times, btn_time_set, editing, blink);
        end
        do_ticks(1);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing, blink} !== {2'b00, 6'd30, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL timeout_1000: got %b/%0d/%b/%b want 00/30/0/0", set_all_times, btn_time_set, editing, blink);
        end
    endtask

    task automatic test_gap_999();
        cur_hour = 6'd5;
        press(0);
        n_cmp++;
        if ({set_all_times, btn_time_set} !== {2'b11, 6'd5}) begin
            n_err++;
            $display("FAIL gap_entry: got %b/%0d want 11/5", set_all_times, btn_time_set);
        end
        do_ticks(995);
        btn_up = 1'b1;
        do_ticks(2);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing, blink} !== {2'b11, 6'd6, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL gap_999_press: got %b/%0d/%b/%b want 11/6/1/1", set_all_times, btn_time_set, editing, blink);
        end
        btn_up = 1'b0;
        do_ticks(2);
    endtask

    task automatic test_reset_mid_edit();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({set_all_times, btn_time_set, editing, blink} !== 10'd0) begin
            n_err++;
            $display("FAIL reset_mid_edit: got %b/%0d/%b/%b want 00/0/0/0", set_all_times, btn_time_set, editing, blink);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; tick_10ms = 1'b0; power_on = 1'b0;
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        cur_hour = 6'd0; cur_minute = 6'd0; cur_second = 6'd0;
        test_reset();
        test_hour_steps();
        test_min_wrap();
        test_auto_repeat();
        test_mode_beats_step();
        test_glitch_and_wrap();
        test_up_down_together();
        test_power_drop();
        test_timeout();
        test_gap_999();
        test_reset_mid_edit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Upstream control stage for the clock/work-time keeper. It turns three raw push-buttons (mode, up, down) into the 2-bit field-select code and 6-bit set value that the keeper consumes.
- Debounces the buttons, walks hour→minute→second edit states, and increments or decrements the selected field with wrap-around.
- Supports auto-repeat and an inactivity timeout.
- Sits between the board button pins and the time keeper; the keeper's current hour/minute/second feed back in so an edit starts from the displayed value.

Parameters:
- DEBOUNCE_TICKS, 2: consecutive stable 10 ms ticks required to accept a level change (20 ms).
- HOLD_TICKS, 50: ticks up/down must be held before auto-repeat starts (500 ms).
- REPEAT_TICKS, 10: ticks between auto-repeat steps (100 ms).
- TIMEOUT_TICKS, 1000: ticks with no accepted press before leaving edit mode (10 s).
- BLINK_TICKS, 50: half-period of the blink output.

Ports:
- clk, input, 1: system clock; the only clock.
- reset, input, 1: synchronous, active-high reset.
- tick_10ms, input, 1: one-clk strobe every 10 ms; all timing counts this strobe.
- power_on, input, 1: unit powered; low forces IDLE.
- btn_mode, input, 1: raw asynchronous mode button, active-high.
- btn_up, input, 1: raw asynchronous increment button, active-high.
- btn_down, input, 1: raw asynchronous decrement button, active-high.
- cur_hour, input, 6: keeper's current hour.
- cur_minute, input, 6: keeper's current minute.
- cur_second, input, 6: keeper's current second.
- set_all_times, output, 2: field select: 00 run, 11 hour, 10 minute, 01 second.
- btn_time_set, output, 6: value written into the selected field.
- editing, output, 1: high in any edit state.
- blink, output, 1: display blink enable for the selected field.

Behaviour:
- Reset, sampled on posedge clk when reset=1: state IDLE, set_all_times=00, btn_time_set=0, editing=0, blink=0. All counters and debounce state clear; debounced levels clear to 0.
- Input conditioning:
  - Each button passes a 2-flop synchronizer.
  - The debounced level updates only when the synchronized value has differed from it for DEBOUNCE_TICKS consecutive tick_10ms strobes. Any bounce restarts the count.
  - A press event is a one-clk pulse on a 0→1 debounced edge. Releases generate nothing.
- Auto-repeat, up/down only:
  - While the debounced level stays high, a hold counter counts ticks.
  - At HOLD_TICKS an extra step event fires, then one every REPEAT_TICKS after that.
  - The counter clears on release.
- FSM, four states, with the state code driving set_all_times directly:
  - IDLE(00) → mode press (only when power_on=1) → EDIT_HOUR(11), with value loaded from cur_hour.
  - EDIT_HOUR → mode press → EDIT_MIN(10), with value loaded from cur_minute.
  - EDIT_MIN → mode press → EDIT_SEC(01), with value loaded from cur_second.
  - EDIT_SEC → mode press → IDLE.
  - Any edit state → IDLE when the timeout counter reaches TIMEOUT_TICKS, or when power_on=0 (same cycle, regardless of other events).
- State entry:
  - The value register is loaded in the same clk edge as the state change, so set_all_times and btn_time_set are never inconsistent for a cycle.
  - On return to IDLE, btn_time_set holds its last value; the keeper ignores it under 00.
- Editing:
  - An up event sets value = (value == LIM-1) ? 0 : value+1.
  - A down event sets value = (value == 0) ? LIM-1 : value-1.
  - LIM is 24 for hour and 60 for minute and second.
  - If a loaded value is ≥ LIM, it is clamped to LIM-1 on load.
  - In IDLE, up/down events are ignored.
- Simultaneous events:
  - Mode and up/down in the same cycle: mode wins, step dropped.
  - Up and down in the same cycle: both dropped.
  - Up and down both held: auto-repeat suppressed.
- Timeout counter:
  - Clears on any accepted press event (mode/up/down, including repeats) and on entry to an edit state.
  - Counts ticks otherwise and saturates at TIMEOUT_TICKS.
- Outputs:
  - editing = (state != IDLE), registered.
  - blink toggles every BLINK_TICKS ticks while editing, resets to 1 on each state entry or step, and is 0 in IDLE.
- Reset mid-edit: immediate return to reset values; no partial value is retained.

Decomposition:
- Package time_pkg:
  - state/field codes FIELD_RUN=2'b00, FIELD_SEC=2'b01, FIELD_MIN=2'b10, FIELD_HOUR=2'b11, shared with the keeper;
  - HOUR_LIM=24 and MIN_SEC_LIM=60.
- Sub-module btn_debounce (sync + debounce + press pulse + optional repeat), instantiated three times. Repeat is disabled for mode via a parameter.

Test Plan:
- Press mode with cur_hour=7, then press up 3 times → set_all_times=11, btn_time_set steps 7→8→9→10; editing=1.
- In EDIT_HOUR with value 23, up → 0. In EDIT_MIN with value 0, down → 59.
- Glitch btn_up high for 1 tick only → no step. Hold 2+ ticks → exactly one step.
- Hold btn_up for 80 ticks in EDIT_SEC starting at 10 → 1 press + repeats at ticks 50,60,70,80 (relative to the debounced edge) → value 15.
- Enter EDIT_MIN, no presses for 1000 ticks → set_all_times returns to 00 and editing=0 on that tick. A 999-tick gap followed by a press keeps the block in edit.
- In EDIT_SEC, mode+up in the same cycle → IDLE with the value unchanged. Drop power_on during EDIT_HOUR → IDLE the next clk. Assert reset mid-edit → all outputs 0.
